// File: rtl/demosaic_ctrl.sv
// Bayer demosaic sequencing controller.
// Tracks frame/line/pixel position of an incoming raster, reports the
// RGGB-cell site of each pixel one cycle after it is accepted (matching the
// window-alignment latency of the demosaic datapath), and flags geometry faults.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   cfg_enable                 run request
//   cfg_pattern                Bayer pattern: 00 RGGB, 01 GRBG, 10 GBRG, 11 BGGR
//   cfg_width, cfg_height      active pixels per line, lines per frame
//   in_vsync, in_de            source frame sync and pixel valid
//   ph_vld, phase              pixel valid and site: 00 R, 01 Gr, 10 Gb, 11 B
//   pix_x, pix_y               coordinates of the reported pixel
//   busy                       high while a frame is being tracked
//   frame_done                 one-cycle pulse per completed frame
//   err_line, err_short        sticky: wrong line length / frame cut short by vsync
//   cfg_err                    sticky: latched geometry below 2x2
//   frame_cnt                  completed frames, wrapping
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | not enabled; inputs ignored
// S_WAIT     | enabled, waiting for a vsync rising edge to latch config
// S_ACTIVE   | tracking pixels/lines of the current frame

module demosaic_ctrl #(
   parameter int CW  = 12,
   parameter int FCW = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           cfg_enable,
   input  logic [1:0]     cfg_pattern,
   input  logic [CW-1:0]  cfg_width,
   input  logic [CW-1:0]  cfg_height,
   input  logic           in_vsync,
   input  logic           in_de,
   output logic           ph_vld,
   output logic [1:0]     phase,
   output logic [CW-1:0]  pix_x,
   output logic [CW-1:0]  pix_y,
   output logic           busy,
   output logic           frame_done,
   output logic           err_line,
   output logic           err_short,
   output logic           cfg_err,
   output logic [FCW-1:0] frame_cnt
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_ACTIVE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic           vs_q, vs_d;
   logic           de_q, de_d;
   logic [1:0]     pat_q, pat_d;
   logic [CW-1:0]  w_q, w_d;
   logic [CW-1:0]  h_q, h_d;
   logic [CW-1:0]  x_q, x_d;
   logic [CW-1:0]  y_q, y_d;
   logic           ph_vld_q, ph_vld_d;
   logic [1:0]     phase_q, phase_d;
   logic [CW-1:0]  pix_x_q, pix_x_d;
   logic [CW-1:0]  pix_y_q, pix_y_d;
   logic           frame_done_q, frame_done_d;
   logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
   logic           err_line_q, err_line_d;
   logic           err_short_q, err_short_d;
   logic           cfg_err_q, cfg_err_d;

   logic           vs_rise;
   logic           cfg_bad;
   logic           line_end;
   logic           last_line;
   logic           start;
   logic [CW-1:0]  x_sat;

   assign vs_rise   = in_vsync & ~vs_q;
   assign cfg_bad   = (cfg_width < CW'(2)) || (cfg_height < CW'(2));
   assign line_end  = (state_q == S_ACTIVE) && de_q && !in_de;
   assign last_line = line_end && ((y_q + CW'(1)) == h_q);
   // x_q counts accepted pixels up to width; the reported coordinate stops at width-1
   assign x_sat     = (x_q < w_q) ? x_q : (w_q - CW'(1));

   always_comb begin
      state_d      = state_q;
      vs_d         = in_vsync;
      de_d         = 1'b0;
      pat_d        = pat_q;
      w_d          = w_q;
      h_d          = h_q;
      x_d          = x_q;
      y_d          = y_q;
      ph_vld_d     = 1'b0;
      phase_d      = 2'b00;
      pix_x_d      = '0;
      pix_y_d      = '0;
      frame_done_d = 1'b0;
      frame_cnt_d  = frame_cnt_q;
      err_line_d   = err_line_q;
      err_short_d  = err_short_q;
      cfg_err_d    = cfg_err_q;
      start        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cfg_enable) begin
               state_d     = S_WAIT;
               err_line_d  = 1'b0;
               err_short_d = 1'b0;
               cfg_err_d   = 1'b0;
            end
         end
         S_WAIT: begin
            if (!cfg_enable) begin
               state_d = S_IDLE;
            end else if (vs_rise) begin
               start = 1'b1;
            end
         end
         S_ACTIVE: begin
            de_d = in_de;
            if (in_de) begin
               ph_vld_d = 1'b1;
               pix_x_d  = x_sat;
               pix_y_d  = y_q;
               phase_d  = {y_q[0] ^ pat_q[1], x_sat[0] ^ pat_q[0]};
               if (x_q < w_q) begin
                  x_d = x_q + CW'(1);
               end else begin
                  err_line_d = 1'b1;
               end
            end
            if (line_end) begin
               x_d = '0;
               y_d = y_q + CW'(1);
               if (x_q != w_q) begin
                  err_line_d = 1'b1;
               end
            end
            if (last_line) begin
               frame_done_d = 1'b1;
               frame_cnt_d  = frame_cnt_q + FCW'(1);
               y_d          = '0;
               if (!cfg_enable) begin
                  state_d = S_IDLE;
               end else if (vs_rise) begin
                  start = 1'b1;
               end else begin
                  state_d = S_WAIT;
               end
            end else if (vs_rise) begin
               // new frame began before this one finished
               err_short_d = 1'b1;
               x_d         = '0;
               y_d         = '0;
               if (cfg_enable) begin
                  start = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (start) begin
         pat_d = cfg_pattern;
         w_d   = cfg_width;
         h_d   = cfg_height;
         x_d   = '0;
         y_d   = '0;
         de_d  = 1'b0;
         if (cfg_bad) begin
            cfg_err_d = 1'b1;
            state_d   = S_WAIT;
         end else begin
            state_d = S_ACTIVE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         vs_q         <= 1'b0;
         de_q         <= 1'b0;
         pat_q        <= 2'b00;
         w_q          <= '0;
         h_q          <= '0;
         x_q          <= '0;
         y_q          <= '0;
         ph_vld_q     <= 1'b0;
         phase_q      <= 2'b00;
         pix_x_q      <= '0;
         pix_y_q      <= '0;
         frame_done_q <= 1'b0;
         frame_cnt_q  <= '0;
         err_line_q   <= 1'b0;
         err_short_q  <= 1'b0;
         cfg_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         vs_q         <= vs_d;
         de_q         <= de_d;
         pat_q        <= pat_d;
         w_q          <= w_d;
         h_q          <= h_d;
         x_q          <= x_d;
         y_q          <= y_d;
         ph_vld_q     <= ph_vld_d;
         phase_q      <= phase_d;
         pix_x_q      <= pix_x_d;
         pix_y_q      <= pix_y_d;
         frame_done_q <= frame_done_d;
         frame_cnt_q  <= frame_cnt_d;
         err_line_q   <= err_line_d;
         err_short_q  <= err_short_d;
         cfg_err_q    <= cfg_err_d;
      end
   end

   assign ph_vld     = ph_vld_q;
   assign phase      = phase_q;
   assign pix_x      = pix_x_q;
   assign pix_y      = pix_y_q;
   assign busy       = (state_q == S_ACTIVE);
   assign frame_done = frame_done_q;
   assign frame_cnt  = frame_cnt_q;
   assign err_line   = err_line_q;
   assign err_short  = err_short_q;
   assign cfg_err    = cfg_err_q;

endmodule
